// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO holding {tlast, tkeep, tdata} per entry with first-word fall-through.
// PACKET_MODE=1 holds words back until a whole packet is stored (store-and-forward).
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [ADDR_WIDTH:0]     count,
  output logic [ADDR_WIDTH:0]     pkt_count,
  output logic                    full,
  output logic                    empty
);

  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = PTR_ONE << ADDR_WIDTH;

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [ENTRY_WIDTH-1:0] headEntry;

  logic [ADDR_WIDTH:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [ADDR_WIDTH:0] pktCount_q, pktCount_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                sReady_q;
  logic                cutThru_q, cutThru_d;

  logic wrEn, rdEn, wrLast, rdLast;

  assign headEntry = mem[rdPtr_q[ADDR_WIDTH-1:0]];
  assign m_tdata   = headEntry[DATA_WIDTH-1:0];
  assign m_tkeep   = headEntry[DATA_WIDTH +: KEEP_WIDTH];
  assign m_tlast   = headEntry[ENTRY_WIDTH-1];

  assign s_tready  = sReady_q;
  assign count     = count_q;
  assign pkt_count = pktCount_q;
  assign full      = full_q;
  assign empty     = empty_q;

  // In packet mode the head is only released once a complete packet is stored,
  // or when cut-through was forced by a packet longer than the FIFO.
  always_comb begin
    if (PACKET_MODE != 0) begin
      m_tvalid = !empty_q && ((pktCount_q != '0) || cutThru_q);
    end else begin
      m_tvalid = !empty_q;
    end
  end

  assign wrEn   = s_tvalid && sReady_q;
  assign rdEn   = m_tvalid && m_tready;
  assign wrLast = wrEn && s_tlast;
  assign rdLast = rdEn && m_tlast;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    pktCount_d = pktCount_q;
    cutThru_d  = cutThru_q;

    if (wrEn) wrPtr_d = wrPtr_q + PTR_ONE;
    if (rdEn) rdPtr_d = rdPtr_q + PTR_ONE;

    // Pointers carry an extra wrap bit, so their difference is the occupancy 0..DEPTH.
    count_d = wrPtr_d - rdPtr_d;
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);

    case ({wrLast, rdLast})
      2'b10:   pktCount_d = pktCount_q + PTR_ONE;
      2'b01:   pktCount_d = pktCount_q - PTR_ONE;
      default: pktCount_d = pktCount_q;
    endcase

    if (PACKET_MODE != 0) begin
      if (full_q && (pktCount_q == '0)) cutThru_d = 1'b1;
      if (rdLast)                       cutThru_d = 1'b0;
    end else begin
      cutThru_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      pktCount_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      sReady_q   <= 1'b0;
      cutThru_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      pktCount_q <= pktCount_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      sReady_q   <= !full_d;
      cutThru_q  <= cutThru_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge aclk) begin
    if (wrEn) begin
      mem[wrPtr_q[ADDR_WIDTH-1:0]] <= {s_tlast, s_tkeep, s_tdata};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: one word-FIFO and one packet-mode instance,
// with a scoreboard queue filled on accepted writes and drained on reads.
module tb_axis_pkt_fifo;

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } beat_t;

  logic        aclk;
  logic        areset_n;
  logic [31:0] sTdata;
  logic [3:0]  sTkeep;
  logic        sTvalid;
  logic        sTlast;
  logic        mTready;
  logic        sel;

  logic        sTvalid0, sTvalid1, mTready0, mTready1;
  logic        sReady0, sReady1, mValid0, mValid1, mLast0, mLast1;
  logic [31:0] mData0, mData1;
  logic [3:0]  mKeep0, mKeep1;
  logic [4:0]  count0, count1, pktCount0, pktCount1;
  logic        full0, full1, empty0, empty1;

  logic        sReady, mValid, mLast, full, empty;
  logic [31:0] mData;
  logic [3:0]  mKeep;
  logic [4:0]  count, pktCount;

  beat_t sb[$];
  int    checks;
  int    errors;
  bit    lastAccepted;
  bit    sawFull;

  axis_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PACKET_MODE(0)) dut0 (
    .aclk(aclk), .areset_n(areset_n),
    .s_tdata(sTdata), .s_tkeep(sTkeep), .s_tvalid(sTvalid0), .s_tlast(sTlast),
    .s_tready(sReady0),
    .m_tdata(mData0), .m_tkeep(mKeep0), .m_tvalid(mValid0), .m_tlast(mLast0),
    .m_tready(mTready0),
    .count(count0), .pkt_count(pktCount0), .full(full0), .empty(empty0)
  );

  axis_pkt_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PACKET_MODE(1)) dut1 (
    .aclk(aclk), .areset_n(areset_n),
    .s_tdata(sTdata), .s_tkeep(sTkeep), .s_tvalid(sTvalid1), .s_tlast(sTlast),
    .s_tready(sReady1),
    .m_tdata(mData1), .m_tkeep(mKeep1), .m_tvalid(mValid1), .m_tlast(mLast1),
    .m_tready(mTready1),
    .count(count1), .pkt_count(pktCount1), .full(full1), .empty(empty1)
  );

  // Only the selected instance sees valid/ready; the other stays idle.
  assign sTvalid0 = sTvalid && !sel;
  assign sTvalid1 = sTvalid && sel;
  assign mTready0 = mTready && !sel;
  assign mTready1 = mTready && sel;

  assign sReady   = sel ? sReady1   : sReady0;
  assign mValid   = sel ? mValid1   : mValid0;
  assign mLast    = sel ? mLast1    : mLast0;
  assign mData    = sel ? mData1    : mData0;
  assign mKeep    = sel ? mKeep1    : mKeep0;
  assign count    = sel ? count1    : count0;
  assign pktCount = sel ? pktCount1 : pktCount0;
  assign full     = sel ? full1     : full0;
  assign empty    = sel ? empty1    : empty0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic last);
    sTdata  = d;
    sTkeep  = d[3:0];
    sTlast  = last;
    sTvalid = 1'b1;
  endtask

  // One clock: score the handshakes visible now, then advance to just after the edge.
  task automatic tick();
    beat_t got;
    beat_t exp;
    lastAccepted = sTvalid && sReady;
    if (mValid && mTready) begin
      checkOutput("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        got = {mLast, mKeep, mData};
        checkOutput("read_beat", 64'(got), 64'(exp));
      end
    end
    if (lastAccepted) begin
      got = {sTlast, sTkeep, sTdata};
      sb.push_back(got);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last);
    applyStimulus(d, last);
    lastAccepted = 1'b0;
    for (int i = 0; i < 64 && !lastAccepted; i++) tick();
    checkOutput("write_accepted", 64'(lastAccepted), 64'd1);
    sTvalid = 1'b0;
  endtask

  task automatic drain(input int maxCycles);
    for (int i = 0; i < maxCycles && (mValid || sb.size() != 0); i++) tick();
    checkOutput("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    sel      = 1'b0;
    areset_n = 1'b0;
    sTdata   = '0;
    sTkeep   = '0;
    sTvalid  = 1'b0;
    sTlast   = 1'b0;
    mTready  = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_sready", 64'(sReady), 64'd0);
    checkOutput("rst_mvalid", 64'(mValid), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_pkt_count", 64'(pktCount), 64'd0);
    areset_n = 1'b1;
    #1;
    checkOutput("sready_before_edge", 64'(sReady), 64'd0);
    @(posedge aclk);
    #1;
    checkOutput("sready_after_edge", 64'(sReady), 64'd1);

    $display("[TB] word mode streaming");
    sel     = 1'b0;
    mTready = 1'b1;
    sendWord(32'h11, 1'b0);
    checkOutput("first_mvalid", 64'(mValid), 64'd1);
    checkOutput("first_mdata", 64'(mData), 64'h11);
    sendWord(32'h22, 1'b0);
    sendWord(32'h33, 1'b0);
    sendWord(32'h44, 1'b1);
    drain(10);
    checkOutput("stream_count", 64'(count), 64'd0);
    checkOutput("stream_empty", 64'(empty), 64'd1);

    $display("[TB] word mode fill");
    mTready = 1'b0;
    for (int i = 0; i < 16; i++) sendWord(32'h100 + 32'(i), (i == 7));
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_sready", 64'(sReady), 64'd0);
    checkOutput("fill_count", 64'(count), 64'd16);
    applyStimulus(32'h117, 1'b0);
    tick();
    checkOutput("held_off_count", 64'(count), 64'd16);
    mTready = 1'b1;
    tick();
    mTready = 1'b0;
    checkOutput("after_read_count", 64'(count), 64'd15);
    checkOutput("after_read_sready", 64'(sReady), 64'd1);
    tick();
    sTvalid = 1'b0;
    checkOutput("refill_count", 64'(count), 64'd16);
    mTready = 1'b1;
    drain(40);
    checkOutput("fill_drain_empty", 64'(empty), 64'd1);

    $display("[TB] packet mode gating");
    sel     = 1'b1;
    mTready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sendWord(32'h200 + 32'(i), 1'b0);
      checkOutput("partial_mvalid", 64'(mValid), 64'd0);
    end
    sendWord(32'h203, 1'b1);
    checkOutput("pkt_count_one", 64'(pktCount), 64'd1);
    checkOutput("pkt_mvalid", 64'(mValid), 64'd1);
    drain(10);
    checkOutput("pkt_count_zero", 64'(pktCount), 64'd0);
    checkOutput("pkt_empty", 64'(empty), 64'd1);

    $display("[TB] packet mode oversized");
    sawFull = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sendWord(32'h300 + 32'(i), (i == 19));
      if (full && pktCount == '0) sawFull = 1'b1;
      if (i == 15) begin
        checkOutput("over_count16", 64'(count), 64'd16);
        checkOutput("over_pkt_zero", 64'(pktCount), 64'd0);
      end
    end
    checkOutput("over_full_seen", 64'(sawFull), 64'd1);
    drain(60);
    checkOutput("over_mvalid_low", 64'(mValid), 64'd0);
    checkOutput("over_empty", 64'(empty), 64'd1);

    $display("[TB] simultaneous read and write");
    mTready = 1'b0;
    for (int i = 0; i < 8; i++) sendWord(32'h400 + 32'(i), 1'b1);
    checkOutput("sim_count_pre", 64'(count), 64'd8);
    checkOutput("sim_pkt_pre", 64'(pktCount), 64'd8);
    applyStimulus(32'h4FF, 1'b1);
    mTready = 1'b1;
    tick();
    sTvalid = 1'b0;
    mTready = 1'b0;
    checkOutput("sim_count_post", 64'(count), 64'd8);
    checkOutput("sim_pkt_post", 64'(pktCount), 64'd8);
    mTready = 1'b1;
    drain(30);

    $display("[TB] reset mid-packet");
    mTready = 1'b0;
    for (int i = 0; i < 5; i++) sendWord(32'h500 + 32'(i), 1'b0);
    checkOutput("midpkt_count", 64'(count), 64'd5);
    areset_n = 1'b0;
    #1;
    checkOutput("midrst_count", 64'(count), 64'd0);
    checkOutput("midrst_empty", 64'(empty), 64'd1);
    checkOutput("midrst_mvalid", 64'(mValid), 64'd0);
    checkOutput("midrst_sready", 64'(sReady), 64'd0);
    sb.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("post_rst_sready", 64'(sReady), 64'd1);
    mTready = 1'b1;
    sendWord(32'hA1, 1'b0);
    sendWord(32'hA2, 1'b1);
    drain(10);
    checkOutput("post_rst_mvalid", 64'(mValid), 64'd0);
    checkOutput("post_rst_pkt", 64'(pktCount), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
